// File: rtl/aes_fifo_pkg.sv
// Shared widths and types for the AES block FIFOs (32-bit host words, 128-bit blocks).
package aes_fifo_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  // Word 0 is the most-significant word, matching the receive-side assembly order.
  function automatic word_t word_of(input block_t blk, input logic [1:0] idx);
    word_t w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fifo_out.sv
// Transmit FIFO: stores whole 128-bit AES result blocks and serves them as
// 32-bit words, most-significant word first, with first-word-fall-through.
module fifo_out
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               write_en,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               read_en,
  output logic [WORD_W-1:0]  data_out,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic               overflow,
  output logic               underflow
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  block_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       word_sel;
  logic [CNT_W-1:0] count;

  logic wr_ok;
  logic rd_ok;
  logic rd_done;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  // Handshake: write_en is a push request accepted only when !fifo_full before
  // the edge; read_en pops the head word only when !fifo_empty. Refused requests
  // are dropped and flagged for one cycle on overflow/underflow.
  assign wr_ok   = write_en && !fifo_full;
  assign rd_ok   = read_en && !fifo_empty;
  assign rd_done = rd_ok && (word_sel == 2'd3);

  always_comb begin
    data_out = '0;
    if (!fifo_empty) data_out = word_of(mem[rd_ptr], word_sel);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      word_sel  <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write_en && fifo_full;
      underflow <= read_en && fifo_empty;

      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);

      if (rd_ok) word_sel <= word_sel + 2'd1;
      if (rd_done) rd_ptr <= rd_ptr + PTR_W'(1);

      // Count tracks blocks including a partially read head, so it only drops
      // when the last word of the head leaves.
      if (wr_ok && !rd_done)      count <= count + CNT_W'(1);
      else if (!wr_ok && rd_done) count <= count - CNT_W'(1);
    end
  end

endmodule
